// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline control: boot sequencing, data-memory wait/timeout,
// hazard front-end freeze, exception flush, stage valids and perf counters.
module pipeline_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_loaduse,
    input  logic             s_branch_jr_ok,
    input  logic             imem_valid,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             s_flush,
    output logic             PIPELINE_READY,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_bubble,
    output logic             pc_sel_flush,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_bj_stall,
    output logic [CNT_W-1:0] cnt_mem_stall,
    output logic [CNT_W-1:0] cnt_retired
);

    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, HALT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  boot_cnt;
    logic [15:0] to_cnt;
    logic [16:0] to_nxt;
    logic        ready;
    logic        hazard;
    logic        mem_stall;
    logic        boot_done;
    logic        to_fire;
    logic        active;

    assign hazard    = id_valid & (s_loaduse | ~s_branch_jr_ok);
    assign mem_stall = dmem_req & mem_valid & ~dmem_ready;
    assign boot_done = (boot_cnt == 8'(BOOT_CYCLES - 1));
    assign to_nxt    = {1'b0, to_cnt} + 17'd1;
    assign to_fire   = (to_nxt >= 17'(MEM_TIMEOUT - 1));
    assign active    = (state == RUN) | (state == MEM_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= BOOT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:     if (boot_done) state_nxt = RUN;
            RUN:      if (mem_stall) state_nxt = MEM_WAIT;
            MEM_WAIT: begin
                if (dmem_ready)   state_nxt = RUN;
                else if (to_fire) state_nxt = HALT;
            end
            HALT:     state_nxt = HALT;
            default:  state_nxt = BOOT;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        unique case (state)
            RUN:      ready = ~mem_stall;
            MEM_WAIT: ready = dmem_ready;
            default:  ready = 1'b0;
        endcase
        PIPELINE_READY = ready;
        if_id_en       = ready & ~hazard;
        pc_en          = (ready & ~hazard & imem_valid) | (ready & s_flush);
        id_ex_bubble   = ready & (hazard | s_flush);
        pc_sel_flush   = ready & s_flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            boot_cnt        <= '0;
            to_cnt          <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            if (state == BOOT && !boot_done) boot_cnt <= boot_cnt + 8'd1;
            if (state == MEM_WAIT) begin
                if (dmem_ready) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_nxt[15:0];
                    if (to_fire) mem_timeout_err <= 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Flush outranks hazard; WB still drains whatever MEM held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else if (ready) begin
            wb_valid <= mem_valid;
            if (s_flush) begin
                id_valid  <= 1'b0;
                ex_valid  <= 1'b0;
                mem_valid <= 1'b0;
            end else if (hazard) begin
                ex_valid  <= 1'b0;
                mem_valid <= ex_valid;
            end else begin
                id_valid  <= imem_valid;
                ex_valid  <= id_valid;
                mem_valid <= ex_valid;
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic en);
        return (en && c != {CNT_W{1'b1}}) ? c + 1'b1 : c;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_loaduse   <= '0;
            cnt_bj_stall  <= '0;
            cnt_mem_stall <= '0;
            cnt_retired   <= '0;
        end else begin
            cnt_loaduse   <= sat_inc(cnt_loaduse, ready & id_valid & s_loaduse);
            cnt_bj_stall  <= sat_inc(cnt_bj_stall,
                                     ready & id_valid & ~s_branch_jr_ok & ~s_loaduse);
            cnt_mem_stall <= sat_inc(cnt_mem_stall, active & ~ready);
            cnt_retired   <= sat_inc(cnt_retired, ready & wb_valid);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table with a valid-bit
// scoreboard, plus boot, memory-wait, timeout and saturation sequences.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s_loaduse, s_branch_jr_ok, imem_valid;
    logic          dmem_req, dmem_ready, s_flush;
    logic          PIPELINE_READY, pc_en, if_id_en, id_ex_bubble, pc_sel_flush;
    logic          id_valid, ex_valid, mem_valid, wb_valid, mem_timeout_err;
    logic [CW-1:0] cnt_loaduse, cnt_bj_stall, cnt_mem_stall, cnt_retired;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       lu, ok, iv, fl, req, rdy;
        logic [4:0] comb;
        logic [3:0] nv;
    } vec_t;

    vec_t       tbl[13];
    logic [3:0] sb[$];
    logic [3:0] exp_v;

    always #5 clk = ~clk;

    pipeline_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_loaduse(s_loaduse), .s_branch_jr_ok(s_branch_jr_ok),
        .imem_valid(imem_valid), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .s_flush(s_flush),
        .PIPELINE_READY(PIPELINE_READY), .pc_en(pc_en),
        .if_id_en(if_id_en), .id_ex_bubble(id_ex_bubble),
        .pc_sel_flush(pc_sel_flush),
        .id_valid(id_valid), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .mem_timeout_err(mem_timeout_err),
        .cnt_loaduse(cnt_loaduse), .cnt_bj_stall(cnt_bj_stall),
        .cnt_mem_stall(cnt_mem_stall), .cnt_retired(cnt_retired)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_loaduse = 0; s_branch_jr_ok = 1; imem_valid = 1;
        dmem_req = 0; dmem_ready = 0; s_flush = 0;
    endtask

    function automatic logic [3:0] vals();
        return {id_valid, ex_valid, mem_valid, wb_valid};
    endfunction

    function automatic logic [4:0] combs();
        return {PIPELINE_READY, pc_en, if_id_en, id_ex_bubble, pc_sel_flush};
    endfunction

    task automatic boot_fill();
        reset_n = 0;
        idle();
        step();
        step();
        reset_n = 1;
        repeat (8) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 1, 1, 0, 0, 0, 5'b11100, 4'b1111};
        tbl[1]  = '{1, 1, 1, 0, 0, 0, 5'b10010, 4'b1011};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 5'b10010, 4'b1001};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 5'b10100, 4'b0100};
        tbl[4]  = '{1, 1, 1, 0, 0, 0, 5'b11100, 4'b1010};
        tbl[5]  = '{1, 1, 1, 1, 0, 0, 5'b11011, 4'b0001};
        tbl[6]  = '{0, 1, 1, 0, 0, 0, 5'b11100, 4'b1000};
        tbl[7]  = '{0, 1, 1, 0, 0, 0, 5'b11100, 4'b1100};
        tbl[8]  = '{0, 1, 1, 0, 0, 0, 5'b11100, 4'b1110};
        tbl[9]  = '{0, 1, 1, 0, 1, 1, 5'b11100, 4'b1111};
        tbl[10] = '{0, 1, 1, 0, 1, 1, 5'b11100, 4'b1111};
        tbl[11] = '{0, 1, 0, 1, 0, 0, 5'b11111, 4'b0001};
        tbl[12] = '{0, 1, 0, 0, 1, 0, 5'b10100, 4'b0000};

        // reset state and boot sequence
        reset_n = 0;
        idle();
        step();
        step();
        chk("rst_ready", PIPELINE_READY, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_if_id_en", if_id_en, 0);
        chk("rst_valids", vals(), 0);
        chk("rst_err", mem_timeout_err, 0);
        chk("rst_cnts", {cnt_loaduse, cnt_bj_stall, cnt_mem_stall, cnt_retired}, 0);
        reset_n = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("boot_ready_low%0d", k), PIPELINE_READY, 0);
            step();
        end
        chk("boot_ready_high", PIPELINE_READY, 1);
        chk("boot_valids0", vals(), 4'b0000);
        step(); chk("fill1", vals(), 4'b1000);
        step(); chk("fill2", vals(), 4'b1100);
        step(); chk("fill3", vals(), 4'b1110);
        step(); chk("fill4", vals(), 4'b1111);
        chk("retired0", cnt_retired, 0);
        step(); chk("retired1", cnt_retired, 1);

        // vector table with scoreboard for next-cycle valids
        for (int i = 0; i < 13; i++) begin
            s_loaduse = tbl[i].lu; s_branch_jr_ok = tbl[i].ok;
            imem_valid = tbl[i].iv; s_flush = tbl[i].fl;
            dmem_req = tbl[i].req; dmem_ready = tbl[i].rdy;
            sb.push_back(tbl[i].nv);
            #1;
            chk($sformatf("vec%0d_comb", i), combs(), tbl[i].comb);
            step();
            if (sb.size() == 0) begin
                chk($sformatf("vec%0d_sb_empty", i), 1, 0);
            end else begin
                exp_v = sb.pop_front();
                chk($sformatf("vec%0d_valids", i), vals(), exp_v);
            end
        end
        chk("tbl_cnt_loaduse", cnt_loaduse, 2);
        chk("tbl_cnt_bj", cnt_bj_stall, 1);
        chk("tbl_cnt_mem", cnt_mem_stall, 0);

        // data-memory wait for 3 cycles then ready
        boot_fill();
        dmem_req = 1; dmem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mw_ready_low%0d", k), PIPELINE_READY, 0);
            chk($sformatf("mw_enables%0d", k), combs(), 0);
            chk($sformatf("mw_valids%0d", k), vals(), 4'b1111);
            step();
        end
        dmem_ready = 1;
        #1;
        chk("mw_ready_cycle", PIPELINE_READY, 1);
        chk("mw_cnt_stall", cnt_mem_stall, 3);
        step();
        dmem_req = 0; dmem_ready = 0;
        #1;
        chk("mw_back_run", PIPELINE_READY, 1);
        chk("mw_cnt_hold", cnt_mem_stall, 3);

        // ready arriving on the last possible cycle wins over timeout
        boot_fill();
        dmem_req = 1; dmem_ready = 0;
        repeat (7) step();
        dmem_ready = 1;
        #1;
        chk("late_ready", PIPELINE_READY, 1);
        step();
        dmem_req = 0; dmem_ready = 0;
        #1;
        chk("late_no_err", mem_timeout_err, 0);
        chk("late_run", PIPELINE_READY, 1);

        // timeout into HALT
        boot_fill();
        dmem_req = 1; dmem_ready = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("to_ready_low%0d", k), PIPELINE_READY, 0);
            chk($sformatf("to_no_err%0d", k), mem_timeout_err, 0);
            step();
        end
        chk("to_err_set", mem_timeout_err, 1);
        chk("to_cnt_stall", cnt_mem_stall, 8);
        dmem_ready = 1; s_flush = 1; imem_valid = 1;
        #1;
        chk("halt_enables", combs(), 0);
        step();
        step();
        chk("halt_err_sticky", mem_timeout_err, 1);
        chk("halt_valids", vals(), 4'b1111);
        chk("halt_cnt_stall", cnt_mem_stall, 8);
        chk("halt_enables2", combs(), 0);
        reset_n = 0;
        #1;
        chk("halt_rst_err", mem_timeout_err, 0);
        chk("halt_rst_valids", vals(), 0);
        chk("halt_rst_cnt", cnt_mem_stall, 0);

        // counter saturation under continuous load-use stall
        boot_fill();
        s_loaduse = 1; s_branch_jr_ok = 0;
        repeat (14) step();
        chk("sat_14", cnt_loaduse, 14);
        repeat (6) step();
        chk("sat_15", cnt_loaduse, 15);
        chk("sat_bj_zero", cnt_bj_stall, 0);
        chk("sat_id_held", id_valid, 1);
        #1;
        chk("sat_enables", combs(), 5'b10010);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
